// File: rtl/io_bus_arbiter_pkg.sv
// Shared types and register-map constants for the GPIO I/O register file arbiter.
// The arbiter FSM encoding and the port register addresses are defined here.
package io_bus_arbiter_pkg;

    localparam int IO_ADDR_W = 6;
    localparam int IO_DATA_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_WR      = 2'd1,
        ARB_RD_ADDR = 2'd2,
        ARB_RD_DATA = 2'd3
    } arb_state_e;

    localparam logic [IO_ADDR_W-1:0] PINB  = 6'h16;
    localparam logic [IO_ADDR_W-1:0] DDRB  = 6'h17;
    localparam logic [IO_ADDR_W-1:0] PORTB = 6'h18;
    localparam logic [IO_ADDR_W-1:0] PINA  = 6'h19;
    localparam logic [IO_ADDR_W-1:0] DDRA  = 6'h1A;
    localparam logic [IO_ADDR_W-1:0] PORTA = 6'h1B;

    // PINx reflect the pads; writes to them are issued but have no effect.
    function automatic logic is_read_only(input logic [IO_ADDR_W-1:0] addr);
        return (addr == PINA) || (addr == PINB);
    endfunction

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Per-requester transaction port: valid/ready request with payload, and a
// registered done pulse carrying err and read data back to the requester.
interface io_bus_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    logic                  valid;
    logic                  ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  done;
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, done, err, rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, done, err, rdata
    );
endinterface

// File: rtl/io_arb_rr.sv
// Two-way round-robin picker: a lone request wins, on contention the
// requester that was not served last wins. Grant is one-hot or zero.
module io_arb_rr (
    input  logic [1:0] valid_i,
    input  logic       rr_last_i,
    input  logic       enable_i,
    output logic [1:0] grant_o
);
    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            unique case (valid_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = rr_last_i ? 2'b01 : 2'b10;
                default: grant_o = 2'b00;
            endcase
        end
    end
endmodule

// File: rtl/io_bus_arbiter.sv
// Arbitrates CPU (r0) and debug bridge (r1) access to the single-port GPIO
// register file and sequences its cs/oe/we bus for one-cycle writes and two-cycle reads.
module io_bus_arbiter
    import io_bus_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    io_bus_arbiter_if.slave       r0_if,
    io_bus_arbiter_if.slave       r1_if,
    output logic                  io_cs,
    output logic                  io_oe,
    output logic                  io_we,
    output logic [ADDR_WIDTH-1:0] io_address,
    inout  wire  [DATA_WIDTH-1:0] io_data
);
    arb_state_e            state_q, state_d;
    logic                  rr_last_q, rr_last_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_WIDTH-1:0] lat_wdata_q, lat_wdata_d;
    logic [1:0]            done_q, done_d;
    logic [1:0]            err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic [1:0]            grant;
    logic                  drive_en;
    logic                  grant_we;

    // No grants while reset is held, so nothing is accepted and then dropped.
    io_arb_rr u_rr (
        .valid_i   ({r1_if.valid, r0_if.valid}),
        .rr_last_i (rr_last_q),
        .enable_i  ((state_q == ARB_IDLE) && !reset),
        .grant_o   (grant)
    );

    assign r0_if.ready = grant[0];
    assign r1_if.ready = grant[1];
    assign r0_if.done  = done_q[0];
    assign r1_if.done  = done_q[1];
    assign r0_if.err   = err_q[0];
    assign r1_if.err   = err_q[1];
    assign r0_if.rdata = rdata0_q;
    assign r1_if.rdata = rdata1_q;

    assign grant_we = grant[1] ? r1_if.we : r0_if.we;
    assign io_data  = drive_en ? lat_wdata_q : {DATA_WIDTH{1'bz}};

    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        owner_d     = owner_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        done_d      = 2'b00;
        err_d       = 2'b00;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        io_cs       = 1'b0;
        io_oe       = 1'b0;
        io_we       = 1'b0;
        io_address  = '0;
        drive_en    = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (|grant) begin
                    owner_d     = grant[1];
                    rr_last_d   = grant[1];
                    lat_addr_d  = grant[1] ? r1_if.addr  : r0_if.addr;
                    lat_wdata_d = grant[1] ? r1_if.wdata : r0_if.wdata;
                    state_d     = grant_we ? ARB_WR : ARB_RD_ADDR;
                end
            end
            ARB_WR: begin
                io_cs          = 1'b1;
                io_we          = 1'b1;
                io_address     = lat_addr_q;
                drive_en       = 1'b1;
                done_d[owner_q] = 1'b1;
                err_d[owner_q]  = is_read_only(lat_addr_q);
                state_d        = ARB_IDLE;
            end
            ARB_RD_ADDR: begin
                io_cs      = 1'b1;
                io_address = lat_addr_q;
                state_d    = ARB_RD_DATA;
            end
            ARB_RD_DATA: begin
                io_cs           = 1'b1;
                io_oe           = 1'b1;
                io_address      = lat_addr_q;
                done_d[owner_q] = 1'b1;
                if (owner_q) rdata1_d = io_data;
                else         rdata0_d = io_data;
                state_d         = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Control and returned-read state; an aborted transaction never reports done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            rr_last_q <= 1'b1;
            owner_q   <= 1'b0;
            done_q    <= 2'b00;
            err_q     <= 2'b00;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            owner_q   <= owner_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    always_ff @(posedge clk) begin
        lat_addr_q  <= lat_addr_d;
        lat_wdata_q <= lat_wdata_d;
    end

endmodule
